// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback (master) and the multi-port register file (slave).
interface regfile_mp_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic                  ready;
  logic [NREAD-1:0]      rd_en;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_valid;
  logic                  we;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;

  modport master (
    input  ready, rd_data, rd_valid,
    output rd_en, rd_addr, we, wr_addr, wr_data
  );

  modport slave (
    output ready, rd_data, rd_valid,
    input  rd_en, rd_addr, we, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD registered read ports, one write port with
// write-to-read bypass, optional hardwired x0 and a post-reset clear sequencer.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW:0] CntLast = (AW+1)'(NREGS - 1);

  localparam logic StClear = 1'b0;
  localparam logic StRun   = 1'b1;

  logic                  state_q, state_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [NREAD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NREAD-1:0]      rd_valid_q, rd_valid_d;

  logic [XLEN-1:0]       mem [NREGS];
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [XLEN-1:0]       mem_wdata;
  logic [AW-1:0]         ra;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    mem_we     = 1'b0;
    mem_waddr  = bus.wr_addr;
    mem_wdata  = bus.wr_data;
    ra         = '0;

    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[AW-1:0];
      mem_wdata = '0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == CntLast) begin
        state_d = StRun;
        ready_d = 1'b1;
      end
    end else begin
      mem_we = bus.we && !(ZERO_REG && bus.wr_addr == '0);
      for (int unsigned i = 0; i < NREAD; i++) begin
        if (bus.rd_en[i]) begin
          ra            = bus.rd_addr[i*AW +: AW];
          rd_valid_d[i] = 1'b1;
          if (ZERO_REG && ra == '0) begin
            rd_data_d[i*XLEN +: XLEN] = '0;
          end else if (bus.we && bus.wr_addr == ra) begin
            rd_data_d[i*XLEN +: XLEN] = bus.wr_data;
          end else begin
            rd_data_d[i*XLEN +: XLEN] = mem[ra];
          end
        end
      end
    end

    // Anything presented on the reset edge, including clear writes, is dropped.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule
